// File: rtl/fpu_pingpong_col_buffer.sv
// fpu_pingpong_col_buffer: ping-pong column buffer packing memory words into FPU input columns
// and FPU result columns back into memory words, with valid/ready on both memory-facing paths.
module fpu_pingpong_col_buffer #(
  parameter int COL_WIDTH      = 10,
  parameter int BUFFER_DEPTH   = 512,
  parameter int MEM_WORD_BYTES = 8,
  parameter int BADDR_BITS     = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BADDR_BITS:0]         cfg_cols,
  input  logic                        fill_valid,
  output logic                        fill_ready,
  input  logic [MEM_WORD_BYTES*8-1:0] fill_data,
  output logic                        rd_bank_valid,
  input  logic                        rd_en,
  input  logic [BADDR_BITS-1:0]       rd_col_addr,
  output logic [COL_WIDTH*8-1:0]      rd_col,
  input  logic                        rd_release,
  output logic                        wr_bank_ready,
  input  logic                        wr_en,
  input  logic [BADDR_BITS-1:0]       wr_col_addr,
  input  logic [(COL_WIDTH-2)*8-1:0]  wr_col,
  input  logic                        wr_commit,
  output logic                        drain_valid,
  input  logic                        drain_ready,
  output logic [MEM_WORD_BYTES*8-1:0] drain_data,
  output logic                        err
);
  localparam int OCW   = COL_WIDTH - 2;
  localparam int IN_B  = BUFFER_DEPTH * COL_WIDTH;
  localparam int OUT_B = BUFFER_DEPTH * OCW;
  localparam int IW    = $clog2(IN_B);
  localparam int OW    = $clog2(OUT_B);
  localparam int PW    = IW + 2;
  // Banks are flat byte arrays: column-major stream offset equals col*CW+row.
  logic [7:0] in_mem  [2][IN_B];
  logic [7:0] out_mem [2][OUT_B];
  logic [1:0] in_full_q, out_full_q;
  logic fill_sel_q, rd_sel_q, wr_sel_q, drain_sel_q, err_q;
  logic [PW-1:0] fill_ptr_q, drain_ptr_q, l_in, l_out;
  logic [COL_WIDTH*8-1:0] rd_col_q;
  logic fill_fire, fill_last, drain_fire, drain_last;
  logic rd_addr_bad, wr_addr_bad, rel_ok, wr_ok, commit_ok, viol;
  assign l_in          = PW'(cfg_cols) * PW'(COL_WIDTH);
  assign l_out         = PW'(cfg_cols) * PW'(OCW);
  assign fill_ready    = !in_full_q[fill_sel_q];
  assign rd_bank_valid = in_full_q[rd_sel_q];
  assign wr_bank_ready = !out_full_q[wr_sel_q];
  assign drain_valid   = out_full_q[drain_sel_q];
  assign rd_col        = rd_col_q;
  assign err           = err_q;
  assign fill_fire     = fill_valid && fill_ready;
  assign fill_last     = fill_ptr_q + PW'(MEM_WORD_BYTES) >= l_in;
  assign drain_fire    = drain_valid && drain_ready;
  assign drain_last    = drain_ptr_q + PW'(MEM_WORD_BYTES) >= l_out;
  assign rd_addr_bad   = rd_en && ({1'b0, rd_col_addr} >= cfg_cols);
  assign wr_addr_bad   = wr_en && ({1'b0, wr_col_addr} >= cfg_cols);
  assign rel_ok        = rd_release && rd_bank_valid;
  assign wr_ok         = wr_en && wr_bank_ready && !wr_addr_bad;
  assign commit_ok     = wr_commit && wr_bank_ready;
  assign viol          = ((rd_en || rd_release) && !rd_bank_valid) ||
                         ((wr_en || wr_commit) && !wr_bank_ready) || rd_addr_bad || wr_addr_bad;
  always_comb begin
    drain_data = '0;
    for (int k = 0; k < MEM_WORD_BYTES; k++)
      drain_data[8*k +: 8] = (drain_ptr_q + PW'(k) < l_out) ?
                             out_mem[drain_sel_q][OW'(drain_ptr_q + PW'(k))] : 8'h00;
  end
  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (fill_fire)
      for (int k = 0; k < MEM_WORD_BYTES; k++)
        if (fill_ptr_q + PW'(k) < l_in)
          in_mem[fill_sel_q][IW'(fill_ptr_q + PW'(k))] <= fill_data[8*k +: 8];
    if (wr_ok)
      for (int r = 0; r < OCW; r++)
        out_mem[wr_sel_q][OW'(int'(wr_col_addr) * OCW + r)] <= wr_col[8*r +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_full_q   <= '0;
      out_full_q  <= '0;
      fill_sel_q  <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_sel_q    <= 1'b0;
      drain_sel_q <= 1'b0;
      fill_ptr_q  <= '0;
      drain_ptr_q <= '0;
      rd_col_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (rd_en)
        for (int r = 0; r < COL_WIDTH; r++)
          rd_col_q[8*r +: 8] <= in_mem[rd_sel_q][IW'(int'(rd_col_addr) * COL_WIDTH + r)];
      if (fill_fire) begin
        fill_ptr_q <= fill_last ? '0 : fill_ptr_q + PW'(MEM_WORD_BYTES);
        if (fill_last) begin
          in_full_q[fill_sel_q] <= 1'b1;
          fill_sel_q            <= !fill_sel_q;
        end
      end
      if (rel_ok) begin
        in_full_q[rd_sel_q] <= 1'b0;
        rd_sel_q            <= !rd_sel_q;
      end
      if (commit_ok) begin
        out_full_q[wr_sel_q] <= 1'b1;
        wr_sel_q             <= !wr_sel_q;
      end
      if (drain_fire) begin
        drain_ptr_q <= drain_last ? '0 : drain_ptr_q + PW'(MEM_WORD_BYTES);
        if (drain_last) begin
          out_full_q[drain_sel_q] <= 1'b0;
          drain_sel_q             <= !drain_sel_q;
        end
      end
      err_q <= err_q || viol;
    end
  end
endmodule

// File: tb/tb_fpu_pingpong_col_buffer.sv
// tb_fpu_pingpong_col_buffer: directed scenarios with hand-computed expectations, cfg_cols = 3.
module tb_fpu_pingpong_col_buffer;
  logic        clk = 0, rst_n = 0;
  logic [9:0]  cfg_cols = 10'd3;
  logic        fill_valid = 0, fill_ready;
  logic [63:0] fill_data = '0;
  logic        rd_bank_valid, rd_en = 0, rd_release = 0;
  logic [8:0]  rd_col_addr = '0, wr_col_addr = '0;
  logic [79:0] rd_col;
  logic        wr_bank_ready, wr_en = 0, wr_commit = 0;
  logic [63:0] wr_col = '0;
  logic        drain_valid, drain_ready = 0;
  logic [63:0] drain_data;
  logic        err;
  int errors = 0, checks = 0;

  fpu_pingpong_col_buffer dut (
    .clk(clk), .rst_n(rst_n), .cfg_cols(cfg_cols),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .rd_bank_valid(rd_bank_valid), .rd_en(rd_en), .rd_col_addr(rd_col_addr), .rd_col(rd_col),
    .rd_release(rd_release), .wr_bank_ready(wr_bank_ready), .wr_en(wr_en),
    .wr_col_addr(wr_col_addr), .wr_col(wr_col), .wr_commit(wr_commit),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_data(drain_data), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] seq_word(input int base);
    for (int k = 0; k < 8; k++) seq_word[8*k +: 8] = 8'(base + k);
  endfunction
  function automatic logic [79:0] seq_col(input int base);
    for (int r = 0; r < 10; r++) seq_col[8*r +: 8] = 8'(base + r);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic fill_word(input int base);
    fill_valid = 1; fill_data = seq_word(base);
    step();
    fill_valid = 0;
  endtask
  task automatic read_col(input int addr);
    rd_en = 1; rd_col_addr = 9'(addr);
    step();
    rd_en = 0;
  endtask
  task automatic release_bank();
    rd_release = 1;
    step();
    rd_release = 0;
  endtask
  task automatic write_col(input int addr, input logic [7:0] v);
    wr_en = 1; wr_col_addr = 9'(addr); wr_col = {8{v}};
    step();
    wr_en = 0;
  endtask
  task automatic commit();
    wr_commit = 1;
    step();
    wr_commit = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({fill_ready, wr_bank_ready, rd_bank_valid, drain_valid} !== 4'b1100) begin errors++; $display("FAIL reset_flags: got %b exp 1100", {fill_ready, wr_bank_ready, rd_bank_valid, drain_valid}); end
    checks++; if (rd_col !== '0 || err !== 1'b0) begin errors++; $display("FAIL reset_rdcol_err: got rd_col=%h err=%b exp 0/0", rd_col, err); end
    rst_n = 1;
    step();
  endtask

  task automatic test_fill_read();
    for (int w = 0; w < 3; w++) fill_word(8*w);
    checks++; if (rd_bank_valid !== 1'b0) begin errors++; $display("FAIL fill_3words_not_full: got %b exp 0", rd_bank_valid); end
    fill_word(24);
    checks++; if (rd_bank_valid !== 1'b1) begin errors++; $display("FAIL fill_bank0_full: got %b exp 1", rd_bank_valid); end
    checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_bank0: got %b exp 1", fill_ready); end
    read_col(2);
    checks++; if (rd_col !== seq_col(20)) begin errors++; $display("FAIL read_col2: got %h exp %h", rd_col, seq_col(20)); end
    read_col(0);
    checks++; if (rd_col !== seq_col(0)) begin errors++; $display("FAIL read_col0: got %h exp %h", rd_col, seq_col(0)); end
  endtask

  task automatic test_pingpong_fill();
    for (int w = 4; w < 8; w++) fill_word(8*w);
    checks++; if (fill_ready !== 1'b0) begin errors++; $display("FAIL both_full_fill_ready: got %b exp 0", fill_ready); end
    release_bank();
    checks++; if (fill_ready !== 1'b1 || rd_bank_valid !== 1'b1) begin errors++; $display("FAIL release_swap: got fill_ready=%b rd_bank_valid=%b exp 1/1", fill_ready, rd_bank_valid); end
    read_col(1);
    checks++; if (rd_col !== seq_col(42)) begin errors++; $display("FAIL read_bank1_col1: got %h exp %h", rd_col, seq_col(42)); end
    release_bank();
    checks++; if (rd_bank_valid !== 1'b0) begin errors++; $display("FAIL release_bank1: got %b exp 0", rd_bank_valid); end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 3; c++) write_col(c, 8'(8'h10 + c));
    commit();
    checks++; if (drain_valid !== 1'b1 || drain_data !== {8{8'h10}}) begin errors++; $display("FAIL drain_word0: got v=%b d=%h exp 1/%h", drain_valid, drain_data, {8{8'h10}}); end
    drain_ready = 1; step(); drain_ready = 0;
    for (int h = 0; h < 5; h++) begin
      checks++; if (drain_valid !== 1'b1 || drain_data !== {8{8'h11}}) begin errors++; $display("FAIL drain_hold%0d: got v=%b d=%h exp 1/%h", h, drain_valid, drain_data, {8{8'h11}}); end
      step();
    end
    drain_ready = 1; step();
    checks++; if (drain_data !== {8{8'h12}}) begin errors++; $display("FAIL drain_word2: got %h exp %h", drain_data, {8{8'h12}}); end
    step(); drain_ready = 0;
    checks++; if (drain_valid !== 1'b0) begin errors++; $display("FAIL drain_bank_freed: got %b exp 0", drain_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got[$];
    logic [7:0] exp_v [6] = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
    for (int c = 0; c < 3; c++) write_col(c, 8'(8'h20 + c));
    commit();
    drain_ready = 1;
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      wr_en = (c < 3); wr_col_addr = 9'(c % 3); wr_col = {8{8'(8'h30 + c)}}; wr_commit = (c == 3);
      if (drain_valid) got.push_back(drain_data);
      step();
    end
    wr_en = 0; wr_commit = 0; drain_ready = 0;
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL b2b_word_count: got %0d exp 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== {8{exp_v[i]}}) begin errors++; $display("FAIL b2b_word%0d: got %h exp %h", i, got[i], {8{exp_v[i]}}); end
    end
    checks++; if (drain_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b exp 0", drain_valid); end
  endtask

  task automatic test_reset_mid_fill();
    read_col(1);
    write_col(0, 8'h55);
    commit();
    fill_word(60); fill_word(68);
    rst_n = 0;
    #1;
    checks++; if ({fill_ready, rd_bank_valid, drain_valid} !== 3'b100 || rd_col !== '0 || err !== 1'b0) begin errors++; $display("FAIL async_reset: got fr/rv/dv=%b rd_col=%h err=%b exp 100/0/0", {fill_ready, rd_bank_valid, drain_valid}, rd_col, err); end
    step();
    rst_n = 1;
    step();
    for (int w = 0; w < 4; w++) fill_word(100 + 8*w);
    read_col(0);
    checks++; if (rd_col !== seq_col(100)) begin errors++; $display("FAIL refill_from_0: got %h exp %h", rd_col, seq_col(100)); end
  endtask

  task automatic test_err_sticky();
    release_bank();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b exp 0", err); end
    read_col(0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b exp 1", err); end
    for (int w = 0; w < 4; w++) fill_word(200 + 8*w);
    read_col(1);
    checks++; if (rd_col !== seq_col(210)) begin errors++; $display("FAIL err_legal_read: got %h exp %h", rd_col, seq_col(210)); end
    release_bank();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", err); end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_pingpong_fill();
    test_drain();
    test_back_to_back();
    test_reset_mid_fill();
    test_err_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
